// File: rtl/data_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// data_unpacker_pkg
//   Shared types and helpers for the trace data unpacker.
//   - state_e    : unpacker FSM states
//   - FW_LEN_*   : firmware chunk-width codes
//   - chunk_len  : decodes a firmware code into a chunk length in elements
// -----------------------------------------------------------------------------
package data_unpacker_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [7:0] FW_LEN_1 = 8'd0;
  localparam logic [7:0] FW_LEN_M = 8'd1;

  // Code 0 -> 1 element, code 1 -> M elements, anything else -> full vector.
  function automatic int chunk_len(input logic [7:0] code, input int m, input int n);
    if (code == FW_LEN_1) return 1;
    if (code == FW_LEN_M) return m;
    return n;
  endfunction

endpackage

// File: rtl/data_unpacker_lane_sel.sv
// -----------------------------------------------------------------------------
// unpack_lane_sel
//   Combinational shifter: output lane i carries buffer element ptr+i.
//   Build option UNPACKER_ZERO_FILL_EN: lanes at or above cnt_i are forced to
//   zero; without it those lanes carry whatever stale buffer element the
//   shifter lands on and consumers must honour the chunk count.
//
//   Ports:
//     buf_i   [N][DW]  latched packed vector
//     ptr_i   [CW]     index of the oldest unsent element
//     cnt_i   [CW]     elements in the current chunk
//     lanes_o [N][DW]  shifted chunk lanes
// -----------------------------------------------------------------------------
module unpack_lane_sel
  import data_unpacker_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic [N-1:0][DW-1:0] buf_i,
  input  logic [CW-1:0]        ptr_i,
  input  logic [CW-1:0]        cnt_i,
  output logic [N-1:0][DW-1:0] lanes_o
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] sel;

    // ptr+i is below 2N, so a match on k or k+N is a full modulo-N wrap.
    // Only lanes past the chunk end ever wrap.
    always_comb begin
      sel = '0;
      for (int k = 0; k < N; k++) begin
        if ((int'(ptr_i) + i == k) || (int'(ptr_i) + i == k + N)) sel = buf_i[k];
      end
`ifdef UNPACKER_ZERO_FILL_EN
      if (i >= int'(cnt_i)) sel = '0;
`endif
    end

    assign lanes_o[i] = sel;
  end

`ifndef UNPACKER_ZERO_FILL_EN
  // Chunk count only matters when zero fill is built in.
  logic unused_cnt;
  assign unused_cnt = ^cnt_i;
`endif

endmodule

// File: rtl/data_unpacker.sv
// -----------------------------------------------------------------------------
// data_unpacker
//   Inverse of the trace data packer. Accepts one packed N-lane vector per
//   handshake and re-emits it as consecutive chunks of 1, M or N elements,
//   the width chosen per chain by an 8-bit firmware code.
//
//   Build option UNPACKER_ZERO_FILL_EN: unused lanes of vector_out are zeroed.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     tracing               when low, accepted vectors are dropped
//     configId, configData  firmware write (configId 1..MAX_CHAINS)
//     valid_in / ready_in   input handshake
//     chainId_in            chain selecting the firmware entry
//     count_in              valid elements in vector_in (clamped to N)
//     vector_in             packed vector, lane 0 oldest
//     valid_out / ready_out output handshake
//     vector_out            chunk, lanes 0..out_count-1 meaningful
//     out_count             elements in this chunk
//     last_out              final chunk of the current vector
// -----------------------------------------------------------------------------
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int N          = 8,
  parameter int M          = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0,
  localparam int CIDW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int CW   = $clog2(N) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tracing,
  input  logic [7:0]                 configId,
  input  logic [7:0]                 configData,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [CIDW-1:0]            chainId_in,
  input  logic [CW-1:0]              count_in,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic [CW-1:0]              out_count,
  output logic                       last_out
);

  state_e                        state_q, state_d;
  logic [N-1:0][DATA_WIDTH-1:0]  buf_q, buf_d;
  logic [CW-1:0]                 ptr_q, ptr_d;
  logic [CW-1:0]                 rem_q, rem_d;
  logic [CW-1:0]                 len_q, len_d;
  logic [MAX_CHAINS-1:0][7:0]    fw_q, fw_d;

  logic          drain, last, acc, hs;
  logic [CW-1:0] cnt, cnt_clamp;
  logic [7:0]    code;

  // All outputs except ready_in decode straight from registered state.
  assign drain     = (state_q == DRAIN);
  assign cnt       = (rem_q < len_q) ? rem_q : len_q;
  assign last      = drain && (rem_q <= len_q);
  assign valid_out = drain;
  assign out_count = drain ? cnt : '0;
  assign last_out  = last;

  // Taking a new vector while the last chunk leaves gives zero-bubble
  // back-to-back vectors; this is the only input-to-output path.
  assign ready_in = !drain || (last && ready_out);
  assign acc      = valid_in && ready_in;
  assign hs       = drain && ready_out;

  assign cnt_clamp = (count_in > CW'(N)) ? CW'(N) : count_in;
  assign code      = (int'(chainId_in) < MAX_CHAINS) ? fw_q[chainId_in] : FW_LEN_1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    fw_d    = fw_q;

    if (hs) begin
      ptr_d = ptr_q + cnt;
      rem_d = rem_q - cnt;
      if (last) state_d = IDLE;
    end

    // An accept can only coincide with the final handshake, so it safely
    // overrides the drain bookkeeping above. Dropped vectors leave no trace.
    if (acc && tracing && (cnt_clamp != '0)) begin
      buf_d   = vector_in;
      len_d   = CW'(chunk_len(code, M, N));
      rem_d   = cnt_clamp;
      ptr_d   = '0;
      state_d = DRAIN;
    end

    // Firmware is read through fw_q above, so a write only affects vectors
    // accepted on later cycles.
    for (int k = 0; k < MAX_CHAINS; k++) begin
      if (int'(configId) == k + 1) fw_d[k] = configData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      fw_q    <= INITIAL_FIRMWARE;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      fw_q    <= fw_d;
    end
  end

  unpack_lane_sel #(
    .N  (N),
    .DW (DATA_WIDTH),
    .CW (CW)
  ) u_lane_sel (
    .buf_i   (buf_q),
    .ptr_i   (ptr_q),
    .cnt_i   (out_count),
    .lanes_o (vector_out)
  );

endmodule

// File: tb/tb_data_unpacker.sv
// -----------------------------------------------------------------------------
// tb_data_unpacker
//   Scoreboard bench for data_unpacker (N=8, M=2, DATA_WIDTH=32, 4 chains).
//   The reference model turns every observed accept into its list of expected
//   chunks; the monitor compares the head chunk whenever valid_out is high
//   and pops it on a handshake.
// -----------------------------------------------------------------------------
module tb_data_unpacker;
  localparam int N = 8, M = 2, DW = 32, MC = 4, CW = 4, CIDW = 2;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    int   cnt;
    bit   last;
    vec_t data;
  } chunk_t;

  logic            clk, rst_n, tracing, valid_in, ready_in, valid_out, ready_out, last_out;
  logic [7:0]      configId, configData;
  logic [CIDW-1:0] chainId_in;
  logic [CW-1:0]   count_in, out_count;
  vec_t            vector_in, vector_out;

  chunk_t sbq[$];
  int     fw_m[MC];
  int     checks = 0, failures = 0;
  int     stall_cnt = 0;
  bit     rnd_rdy = 0;

  data_unpacker #(.N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .INITIAL_FIRMWARE('0)) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .configId(configId), .configData(configData),
    .valid_in(valid_in), .ready_in(ready_in), .chainId_in(chainId_in), .count_in(count_in),
    .vector_in(vector_in), .valid_out(valid_out), .ready_out(ready_out),
    .vector_out(vector_out), .out_count(out_count), .last_out(last_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: a vector becomes ceil(c/L) chunks of L elements, the
  // final one possibly short.
  task automatic model_accept(input int ch, input int cin, input vec_t v);
    int c, L, p, n;
    chunk_t e;
    if (!tracing || cin == 0) return;
    c = (cin > N) ? N : cin;
    L = (fw_m[ch] == 0) ? 1 : (fw_m[ch] == 1) ? M : N;
    for (p = 0; p < c; p += n) begin
      n = (c - p < L) ? c - p : L;
      e.cnt = n; e.last = (p + n == c); e.data = '0;
      for (int j = 0; j < n; j++) e.data[j] = v[p + j];
      sbq.push_back(e);
    end
  endtask

  // Model observer: accepts use firmware as it stood before this cycle's write.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (valid_in && ready_in) model_accept(int'(chainId_in), int'(count_in), vector_in);
      if (configId >= 1 && configId <= MC) fw_m[configId - 1] = int'(configData);
    end
  end

  // Monitor
  always @(negedge clk) begin
    chunk_t e;
    bit exp_rdy, ok;
    exp_rdy = (sbq.size() == 0) || (sbq.size() == 1 && ready_out);
    checks++;
    if (ready_in !== exp_rdy) begin
      failures++; $display("FAIL ready_in: got %b want %b at %0t", ready_in, exp_rdy, $time);
    end
    checks++;
    if (valid_out !== (sbq.size() != 0)) begin
      failures++; $display("FAIL valid_out: got %b want %b at %0t", valid_out, sbq.size() != 0, $time);
    end
    if (valid_out === 1'b1 && sbq.size() != 0) begin
      e = sbq[0];
      checks++;
      if (int'(out_count) != e.cnt || last_out !== e.last) begin
        failures++;
        $display("FAIL count_last: got %0d/%b want %0d/%b at %0t", out_count, last_out, e.cnt, e.last, $time);
      end
      ok = 1;
      for (int j = 0; j < N; j++) begin
        if (j < e.cnt) begin
          if (vector_out[j] !== e.data[j]) ok = 0;
        end
`ifdef UNPACKER_ZERO_FILL_EN
        else if (vector_out[j] !== '0) ok = 0;
`endif
      end
      checks++;
      if (!ok) begin
        failures++; $display("FAIL vector_out: got %h want %h at %0t", vector_out, e.data, $time);
      end
      if (ready_out) void'(sbq.pop_front());
    end
  end

  // Downstream ready driver
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      ready_out = 0; stall_cnt--;
    end else ready_out = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
  end

  function automatic vec_t seqv(input int base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = DW'(base + i);
    return v;
  endfunction

  function automatic vec_t rv();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic cfg(input int id, input int d);
    configId = 8'(id); configData = 8'(d);
    @(posedge clk); #1;
    configId = 0;
  endtask

  task automatic send(input int ch, input int cnt, input vec_t v, input bit keep);
    int b = 0;
    bit a;
    valid_in = 1; chainId_in = CIDW'(ch); count_in = CW'(cnt); vector_in = v;
    do begin
      @(negedge clk); a = ready_in;
      @(posedge clk); #1; b++;
    end while (!a && b < 200);
    checks++;
    if (!a) begin failures++; $display("FAIL send_accept: got 0 want 1 at %0t", $time); end
    if (!keep) valid_in = 0;
  endtask

  task automatic drain();
    int b = 0;
    while (sbq.size() != 0 && b < 500) begin @(posedge clk); #1; b++; end
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; tracing = 1; valid_in = 0; ready_out = 1; configId = 0; configData = 0;
    chainId_in = 0; count_in = 0; vector_in = '0;
    for (int i = 0; i < MC; i++) fw_m[i] = 0;
    #12;
    checks++;
    if (valid_out !== 0 || last_out !== 0 || out_count !== 0 || vector_out !== '0 || ready_in !== 1) begin
      failures++;
      $display("FAIL reset_state: got v%b l%b c%0d r%b want v0 l0 c0 r1", valid_out, last_out, out_count, ready_in);
    end
    #1 rst_n = 1;
    @(posedge clk); #1;

    // M chunks of a full vector
    cfg(1, 1); send(0, 8, seqv(0), 0); drain();
    // single-element chunks
    cfg(1, 0); send(0, 3, seqv(10), 0); drain();
    // partial final chunk
    cfg(1, 1); send(0, 5, rv(), 0); drain();
    // stall during second chunk
    send(0, 8, seqv(100), 0); #2; stall_cnt = 3; drain();
    // back-to-back full-width vectors
    cfg(2, 2); send(1, 8, seqv(200), 1); send(1, 8, seqv(300), 0); drain();
    // tracing off: accepted and dropped
    tracing = 0; send(1, 8, rv(), 1); send(1, 4, rv(), 0); tracing = 1;
    repeat (3) @(posedge clk); #1;
    drain();

    // random traffic
    rnd_rdy = 1;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(3) == 0) cfg($urandom_range(6), $urandom_range(3));
      tracing = ($urandom_range(7) != 0);
      send($urandom_range(MC - 1), $urandom_range(15), rv(), 1'($urandom_range(1)));
    end
    valid_in = 0; tracing = 1;
    drain();
    rnd_rdy = 0;
    repeat (2) @(posedge clk); #1;

    // reset mid-drain
    cfg(1, 1); send(0, 8, seqv(400), 0);
    @(posedge clk); #2;
    rst_n = 0; sbq.delete();
    for (int i = 0; i < MC; i++) fw_m[i] = 0;
    #1;
    checks++;
    if (valid_out !== 0 || ready_in !== 1 || out_count !== 0) begin
      failures++; $display("FAIL async_reset: got v%b r%b c%0d want v0 r1 c0", valid_out, ready_in, out_count);
    end
    @(posedge clk); @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    send(0, 3, seqv(500), 0); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_unpacker.md
Name: data_unpacker

Overview:
- Inverse of the trace data packer. Accepts one packed N-lane vector per handshake and re-emits it as consecutive chunks of 1, M or N elements.
- Chunk width is selected per chain by firmware.
- Sits downstream of the packer, e.g. on the trace readback path, feeding blocks that consume narrow vectors.
- Ready/valid handshake on both sides, with back-pressure.

Parameters:
- N, 8, lanes per packed vector.
- M, 2, medium chunk width; 1<M<N.
- DATA_WIDTH, 32, bits per element.
- MAX_CHAINS, 4, number of firmware entries.
- INITIAL_FIRMWARE, all 0, per-chain chunk code at reset (8 bits each).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tracing  in  1  enable; when low, new inputs are discarded.
- configId  in  8  0 = no write; k in 1..MAX_CHAINS writes firmware[k-1].
- configData  in  8  firmware value written.
- valid_in  in  1  input vector valid.
- ready_in  out  1  unpacker can accept a vector.
- chainId_in  in  $clog2(MAX_CHAINS) (min 1)  chain of the input vector.
- count_in  in  $clog2(N)+1  valid elements in vector_in (1..N); lane 0 is oldest.
- vector_in  in  DATA_WIDTH x N  packed vector.
- valid_out  out  1  chunk valid.
- ready_out  in  1  downstream accepts chunk.
- vector_out  out  DATA_WIDTH x N  chunk; lanes 0..out_count-1 meaningful.
- out_count  out  $clog2(N)+1  elements in this chunk.
- last_out  out  1  final chunk of the current vector.

Behaviour:
- Asynchronous reset: state IDLE, valid_out=0, last_out=0, out_count=0, vector_out=0, firmware=INITIAL_FIRMWARE, buffer and pointer cleared.
- Firmware decode: code 0 -> L=1; code 1 -> L=M; any other code -> L=N.
- Firmware write: when configId is in 1..MAX_CHAINS, firmware[configId-1]<=configData at the clock edge. configId values above MAX_CHAINS are ignored. A write takes effect only for vectors accepted after the write cycle.
- Accept condition: valid_in && ready_in. On accept:
  - if tracing=1: latch vector_in, L from firmware[chainId_in], remaining=min(count_in,N), ptr=0.
  - if tracing=0 or count_in=0: the vector is consumed and dropped; no chunks are produced.
- States:
  - IDLE: ready_in=1, valid_out=0. A latched accept moves to DRAIN.
  - DRAIN: valid_out=1.
    - vector_out lane i = buffer[ptr+i] for i<out_count.
    - out_count=min(L,remaining).
    - last_out=(remaining<=L).
    - On a handshake (valid_out && ready_out): ptr+=out_count, remaining-=out_count.
    - On a handshake with last_out: go to IDLE, or stay in DRAIN if a new vector is accepted in the same cycle.
- ready_in = IDLE || (DRAIN && last_out && ready_out). This gives zero-bubble back-to-back vectors. ready_in is the only combinational in-to-out path.
- Latency: vector accepted at edge t -> first chunk valid in the cycle after edge t. Sustained rate is one chunk per cycle when ready_out=1.
- Stall: while valid_out && !ready_out, vector_out, out_count and last_out hold stable.
- Other cases:
  - count_in>N is clamped to N.
  - A partial last chunk is emitted with out_count<L.
  - tracing falling during DRAIN does not abort the current vector.
  - Reset asserted mid-drain drops the buffered data immediately; no chunk completes.

Optional Feature:
- Macro: UNPACKER_ZERO_FILL_EN.
- Defined: lanes >= out_count of vector_out are driven to 0.
- Undefined: those lanes carry unspecified stale buffer data, saving muxing. Consumers must use out_count.

Decomposition:
- Package data_unpacker_pkg:
  - state enum {IDLE, DRAIN}.
  - firmware codes FW_LEN_1=8'd0, FW_LEN_M=8'd1.
  - function decoding a code to chunk length.
- Sub-module unpack_lane_sel: combinational shifter from (buffer, ptr, out_count) to the vector_out lanes. Zero-fill is applied here.

Test Plan (N=8, M=2, DATA_WIDTH=32):
- Firmware[0]=1; vector 0..7, count 8, ready_out=1 -> chunks {0,1},{2,3},{4,5},{6,7}, out_count=2 each; last_out on the 4th; ready_in high in that cycle.
- configId=1, configData=0, then vector {10,11,12}, count 3 -> chunks 10, 11, 12 with out_count=1; last_out on 12.
- M mode, count 5 -> chunks of 2, 2, 1; final chunk lane0=element 4, out_count=1, last_out=1.
- ready_out low for 3 cycles during the 2nd chunk -> valid_out stays 1 and outputs are unchanged; the chunk sequence resumes intact.
- Two vectors with valid_in held high, firmware code 2 (L=8) -> one chunk per cycle with no idle cycle between vectors. With tracing=0 -> both accepted and valid_out never rises.
- rst_n pulsed low mid-DRAIN -> valid_out=0 asynchronously; after release ready_in=1 and firmware reverts to INITIAL_FIRMWARE.
